// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory and decode.
// The master side is the fetch unit; the slave side is memory plus decode/redirect logic.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc8;
    logic        fetch_err;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc, inst_pc8,
        input  inst_ready,
        output fetch_err
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc, inst_pc8,
        output inst_ready,
        input  fetch_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order memory requests, DEPTH-entry instruction queue with per-entry PC,
// redirect flush with drain of in-flight responses, sticky error on unsolicited responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] { IDLE, FETCH, DRAIN } state_t;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    state_t      state;
    logic [31:0] fetch_pc;
    cnt_t        outstanding;
    cnt_t        occupancy;
    cnt_t        drop_cnt;
    ptr_t        q_head;
    ptr_t        q_tail;
    ptr_t        af_head;
    ptr_t        af_tail;
    logic        fetch_err_q;

    logic [31:0] q_data [DEPTH];
    logic [31:0] q_pc   [DEPTH];
    logic [31:0] af_pc  [DEPTH];

    logic        head_valid;
    logic        pop;
    logic        req_fire;
    logic        rsp_counted;
    logic        rsp_accept;
    logic        rsp_spurious;
    logic [CW:0] slots_used;
    cnt_t        out_after_rsp;
    logic [31:0] head_pc;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // A same-cycle pop frees a slot, which is what sustains one instruction per cycle.
    assign head_valid    = (occupancy != '0) && !bus.redirect_valid;
    assign pop           = head_valid && bus.inst_ready;
    assign slots_used    = {1'b0, outstanding} + {1'b0, occupancy} - {{CW{1'b0}}, pop};
    assign req_fire      = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_counted   = bus.imem_rsp_valid && (outstanding != '0);
    assign rsp_accept    = rsp_counted && (state == FETCH) && !bus.redirect_valid;
    assign rsp_spurious  = bus.imem_rsp_valid && (outstanding == '0) && (drop_cnt == '0);
    assign out_after_rsp = outstanding - cnt_t'(rsp_counted);

    assign head_pc            = head_valid ? q_pc[q_head] : '0;
    assign bus.imem_req_valid = (state == FETCH) && (slots_used < DEPTH_W) && !bus.redirect_valid;
    assign bus.imem_addr      = fetch_pc;
    assign bus.inst_valid     = head_valid;
    assign bus.inst           = head_valid ? q_data[q_head] : '0;
    assign bus.inst_pc        = head_pc;
    assign bus.inst_pc8       = head_pc + 32'd8;
    assign bus.fetch_err      = fetch_err_q;

    always_ff @(posedge clk) begin
        if (req_fire) begin
            af_pc[af_tail] <= fetch_pc;
        end
        if (rsp_accept) begin
            q_data[q_tail] <= bus.imem_rsp_data;
            q_pc[q_tail]   <= af_pc[af_head];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            occupancy   <= '0;
            drop_cnt    <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            af_head     <= '0;
            af_tail     <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            if (rsp_spurious) begin
                fetch_err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (bus.redirect_valid) begin
                        // Requests still in flight become drops; their address slots are discarded.
                        fetch_pc    <= {bus.redirect_pc[31:2], 2'b00};
                        occupancy   <= '0;
                        q_head      <= '0;
                        q_tail      <= '0;
                        af_head     <= '0;
                        af_tail     <= '0;
                        outstanding <= '0;
                        drop_cnt    <= out_after_rsp;
                        state       <= (out_after_rsp != '0) ? DRAIN : FETCH;
                    end else begin
                        if (req_fire) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            af_tail  <= ptr_inc(af_tail);
                        end
                        if (rsp_accept) begin
                            q_tail  <= ptr_inc(q_tail);
                            af_head <= ptr_inc(af_head);
                        end
                        if (pop) begin
                            q_head <= ptr_inc(q_head);
                        end
                        outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_accept);
                        occupancy   <= occupancy + cnt_t'(rsp_accept) - cnt_t'(pop);
                    end
                end
                DRAIN: begin
                    if (bus.redirect_valid) begin
                        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                    end
                    if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
                        drop_cnt <= drop_cnt - cnt_t'(1);
                    end
                    if ((drop_cnt == '0) && !bus.redirect_valid) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory/decode/redirect traffic
// checked against a transaction-level model of requests, drops and the instruction stream.
module tb_fetch_unit;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] addr;
        int unsigned ep;
        int unsigned rdy;
    } req_t;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic reset_w = 1'b1;

    fetch_unit_if bus ();
    fetch_unit_if wbus ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
        .clk   (clk),
        .reset (reset_w),
        .bus   (wbus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    req_t        pend[$];
    logic [31:0] exp_pc[$];
    logic        exp_err;
    logic [31:0] next_addr;
    int unsigned epoch;
    int unsigned cyc = 0;
    int unsigned pops = 0;
    int unsigned cfg_ready, cfg_rsp, cfg_dec, cfg_redir, cfg_lat;
    logic        prev_hold;
    logic [31:0] prev_pc, prev_inst;
    logic        last_rv, last_iv, last_err;
    logic [31:0] last_addr, last_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0F96;
    endfunction

    task automatic set_cfg(input int unsigned rdy, input int unsigned rsp, input int unsigned dec,
                           input int unsigned redir, input int unsigned lat);
        cfg_ready = rdy;
        cfg_rsp   = rsp;
        cfg_dec   = dec;
        cfg_redir = redir;
        cfg_lat   = lat;
    endtask

    task automatic inputs_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inputs_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pend.delete();
        exp_pc.delete();
        exp_err   = 1'b0;
        next_addr = RESET_PC;
        epoch     = 0;
        prev_hold = 1'b0;
        @(negedge clk);
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_inst_pc", bus.inst_pc, 0);
        check("rst_fetch_err", bus.fetch_err, 0);
        check("rst_imem_addr", bus.imem_addr, RESET_PC);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive();
        bus.imem_req_ready = ($urandom_range(0, 99) < cfg_ready);
        if (pend.size() != 0 && pend[0].rdy <= cyc && $urandom_range(0, 99) < cfg_rsp) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        bus.inst_ready     = ($urandom_range(0, 99) < cfg_dec);
        bus.redirect_valid = ($urandom_range(0, 99) < cfg_redir);
        bus.redirect_pc    = $urandom;
    endtask

    // One cycle: sample at the falling edge, compare against the model, then advance the model.
    task automatic tick();
        logic        rv, rr, iv, ir, rdv, rsv, err;
        logic [31:0] addr, ipc, iw, ipc8, rdpc;
        int          live, old, used;
        req_t        r;
        @(negedge clk);
        rv   = bus.imem_req_valid;
        rr   = bus.imem_req_ready;
        addr = bus.imem_addr;
        iv   = bus.inst_valid;
        ir   = bus.inst_ready;
        iw   = bus.inst;
        ipc  = bus.inst_pc;
        ipc8 = bus.inst_pc8;
        rdv  = bus.redirect_valid;
        rdpc = bus.redirect_pc;
        rsv  = bus.imem_rsp_valid;
        err  = bus.fetch_err;
        live = 0;
        old  = 0;
        foreach (pend[i]) begin
            if (pend[i].ep == epoch) live++;
            else old++;
        end
        used = live + exp_pc.size() - ((iv && ir) ? 1 : 0);

        check("imem_addr", addr, next_addr);
        check("fetch_err", err, exp_err);
        check("inst_valid", iv, (exp_pc.size() != 0) && !rdv);
        if (iv) begin
            if (exp_pc.size() != 0) begin
                check("inst_pc", ipc, exp_pc[0]);
                check("inst", iw, mem_word(exp_pc[0]));
            end
            check("inst_pc8", ipc8, ipc + 32'd8);
            if (prev_hold) begin
                check("hold_pc", ipc, prev_pc);
                check("hold_inst", iw, prev_inst);
            end
        end else begin
            check("idle_inst", iw, 0);
            check("idle_inst_pc", ipc, 0);
        end
        if (rdv || old != 0 || used >= int'(DEPTH)) begin
            check("req_gated", rv, 1'b0);
        end

        last_rv   = rv;
        last_iv   = iv;
        last_err  = err;
        last_addr = addr;
        last_pc   = ipc;
        prev_hold = iv && !ir;
        prev_pc   = ipc;
        prev_inst = iw;

        if (iv && ir) begin
            if (exp_pc.size() != 0) void'(exp_pc.pop_front());
            pops++;
        end
        if (rsv) begin
            if (pend.size() == 0) begin
                exp_err = 1'b1;
            end else begin
                r = pend.pop_front();
                if (!rdv && r.ep == epoch) exp_pc.push_back(r.addr);
            end
        end
        if (rdv) begin
            exp_pc.delete();
            epoch++;
            next_addr = {rdpc[31:2], 2'b00};
        end
        if (rv && rr) begin
            r.addr = addr;
            r.ep   = epoch;
            r.rdy  = cyc + 1 + $urandom_range(0, cfg_lat);
            pend.push_back(r);
            next_addr = next_addr + 32'd4;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int unsigned n);
        repeat (n) begin
            drive();
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        inputs_idle();
        wbus.imem_req_ready = 1'b1;
        wbus.imem_rsp_valid = 1'b0;
        wbus.imem_rsp_data  = '0;
        wbus.redirect_valid = 1'b0;
        wbus.redirect_pc    = '0;
        wbus.inst_ready     = 1'b0;
        set_cfg(100, 100, 100, 0, 0);

        // Address wrap on the second instance
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_w = 1'b0;
        @(negedge clk);
        check("wrap_idle_req", wbus.imem_req_valid, 0);
        check("wrap_addr_idle", wbus.imem_addr, WRAP_PC);
        @(negedge clk);
        check("wrap_req0", wbus.imem_req_valid, 1);
        check("wrap_addr0", wbus.imem_addr, WRAP_PC);
        @(negedge clk);
        check("wrap_req1", wbus.imem_req_valid, 1);
        check("wrap_addr1", wbus.imem_addr, 32'h0000_0000);
        @(posedge clk);
        #1;

        // Streaming at one instruction per cycle
        do_reset();
        set_cfg(100, 100, 100, 0, 0);
        run(4);
        pops = 0;
        run(16);
        check("stream_rate", pops, 16);

        // Back-pressure from decode
        cfg_dec = 0;
        run(5);
        check("bp_req_valid", last_rv, 0);
        check("bp_head_valid", last_iv, 1);
        cfg_dec = 100;
        run(10);

        // Redirect with two requests in flight
        cfg_rsp = 0;
        run(3);
        check("pre_redir_req_valid", last_rv, 0);
        check("pre_redir_inst_valid", last_iv, 0);
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        tick();
        cfg_rsp = 100;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive();
            tick();
            seen = last_rv;
        end
        check("redir_req_seen", seen, 1);
        check("redir_addr", last_addr, 32'h0000_0100);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive();
            tick();
            seen = last_iv;
        end
        check("redir_head_seen", seen, 1);
        check("redir_head_pc", last_pc, 32'h0000_0100);

        // Misaligned redirect colliding with a response and a decode pop
        run(6);
        check("coll_pre_head", last_iv, 1);
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        if (pend.size() != 0 && pend[0].rdy <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0203;
        tick();
        check("coll_inst_valid", last_iv, 0);
        drive();
        tick();
        check("coll_fetch_pc", last_addr, 32'h0000_0200);
        check("coll_req_valid", last_rv, 1);
        run(10);

        // Unsolicited response, then reset clears the flag
        do_reset();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
        bus.imem_rsp_valid = 1'b0;
        tick();
        check("spurious_err", last_err, 1);
        do_reset();

        // Randomized traffic with occasional mid-stream resets
        pops = 0;
        for (int seg = 0; seg < 40; seg++) begin
            set_cfg($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100),
                    $urandom_range(0, 8), $urandom_range(0, 3));
            if (seg % 10 == 9) do_reset();
            run(100);
        end
        check("random_progress", (pops > 200), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
